// File: rtl/clk_div_ctrl.sv
// Scale controller for the programmable clock divider: round-robin arbitration of scale
// requests, applied just after a falling edge of div_clk_out. Optional macro: CLK_DIV_CTRL_TIMEOUT_EN.
module clk_div_ctrl #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned SCALE_W       = 32,
    parameter int unsigned DEFAULT_SCALE = 1000,
    parameter int unsigned MIN_SCALE     = 2,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SCALE_W-1:0] req_scale,
    output logic [NREQ-1:0]         gnt,
    output logic                    clamped,
    output logic                    busy,
    input  logic                    div_clk_out,
    output logic [SCALE_W-1:0]      scale,
    output logic                    div_reset,
    output logic                    timeout
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, LOAD, ACK} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [SCALE_W-1:0] pend_q, pend_d;
    logic               clamp_q, clamp_d;
    logic               edge_q;
    logic               fall;
    logic               force_load;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [SCALE_W-1:0] pick_raw;
    logic [SCALE_W-1:0] pick_clamp;
    logic               pick_low;

    assign fall = edge_q & ~div_clk_out;

    // Round-robin search starting at the pointer
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = ptr_q;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign pick_raw   = req_scale[32'(pick) * SCALE_W +: SCALE_W];
    assign pick_low   = (pick_raw < SCALE_W'(MIN_SCALE));
    assign pick_clamp = pick_low ? SCALE_W'(MIN_SCALE) : pick_raw;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        pend_d  = pend_q;
        clamp_d = clamp_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    pend_d  = pick_clamp;
                    clamp_d = pick_low;
                    state_d = (pick_clamp == scale) ? ACK : WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (fall || force_load) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
                ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs follow the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            pend_q    <= '0;
            clamp_q   <= 1'b0;
            edge_q    <= 1'b0;
            scale     <= SCALE_W'(DEFAULT_SCALE);
            div_reset <= 1'b1;
            gnt       <= '0;
            clamped   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            pend_q    <= pend_d;
            clamp_q   <= clamp_d;
            edge_q    <= div_clk_out;
            busy      <= (state_d != IDLE);
            div_reset <= (state_d == LOAD);
            gnt       <= (state_d == ACK) ? (NREQ'(1) << win_d) : '0;
            clamped   <= (state_d == ACK) && clamp_d;
            if (state_d == LOAD) begin
                scale <= pend_d;
            end
        end
    end

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             forced_q;

    assign force_load = (state_q == WAIT_EDGE) && !fall && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Edge-wait counter, restarted on every WAIT_EDGE entry; forced flag reported in ACK
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            forced_q <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            cnt_q   <= (state_q == WAIT_EDGE) ? cnt_q + 1'b1 : '0;
            timeout <= (state_d == ACK) && forced_q;
            if (state_q == ACK) begin
                forced_q <= 1'b0;
            end else if (force_load) begin
                forced_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign force_load         = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized scoreboard bench for clk_div_ctrl; expected grants come from a round-robin
// service model, checked by an independent monitor whenever gnt is presented.
module tb_clk_div_ctrl;
    localparam int unsigned NREQ = 4;
    localparam int unsigned SW   = 32;
    localparam int unsigned DEF  = 1000;
    localparam int unsigned MINS = 2;
    localparam int unsigned TMO  = 16;

    typedef struct {
        int          idx;
        logic [SW-1:0] scale;
        bit          clamped;
        bit          load;
        bit          tmo;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*SW-1:0] req_scale;
    logic [NREQ-1:0]    gnt;
    logic               clamped;
    logic               busy;
    logic               div_clk_out;
    logic [SW-1:0]      scale;
    logic               div_reset;
    logic               timeout;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        exp_q[$];
    int          ptr_m   = 0;
    logic [SW-1:0] scale_m = DEF;
    logic [SW-1:0] b_scale [NREQ];
    int          b_cnt   [NREQ];

    bit hold_mode    = 1'b0;
    bit hold_val     = 1'b0;
    bit no_edge_mode = 1'b0;

    clk_div_ctrl #(
        .NREQ(NREQ), .SCALE_W(SW), .DEFAULT_SCALE(DEF), .MIN_SCALE(MINS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_scale(req_scale), .gnt(gnt),
        .clamped(clamped), .busy(busy), .div_clk_out(div_clk_out), .scale(scale),
        .div_reset(div_reset), .timeout(timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        n_checks++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req_v);
    endtask

    // Divider output stand-in: random toggling, or held at a fixed level
    initial begin : div_gen
        int tog;
        tog = 0;
        div_clk_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_mode) begin
                div_clk_out = hold_val;
            end else if (tog == 0) begin
                div_clk_out = ~div_clk_out;
                tog = int'($urandom_range(1, 4));
            end else begin
                tog--;
            end
        end
    end

    // Service model: every held request is served its count of times, round-robin from the pointer
    function automatic void model_batch();
        int   rem [NREQ];
        int   left;
        int   idx;
        exp_t e;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = b_cnt[i];
            left += b_cnt[i];
        end
        while (left > 0) begin
            idx = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (idx < 0 && rem[(ptr_m + k) % NREQ] > 0) idx = (ptr_m + k) % NREQ;
            end
            e.idx     = idx;
            e.clamped = (b_scale[idx] < MINS);
            e.scale   = e.clamped ? SW'(MINS) : b_scale[idx];
            e.load    = (e.scale != scale_m);
            e.tmo     = 1'b0;
            exp_q.push_back(e);
            scale_m = e.scale;
            ptr_m   = (idx + 1) % NREQ;
            rem[idx]--;
            left--;
        end
    endfunction

    task automatic set_batch(input int s0, input int s1, input int s2, input int s3,
                             input int c0, input int c1, input int c2, input int c3);
        b_scale[0] = SW'(s0); b_scale[1] = SW'(s1); b_scale[2] = SW'(s2); b_scale[3] = SW'(s3);
        b_cnt[0] = c0; b_cnt[1] = c1; b_cnt[2] = c2; b_cnt[3] = c3;
    endtask

    task automatic run_batch();
        int rem [NREQ];
        int total;
        int guard;
        total = 0;
        model_batch();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = b_cnt[i];
            total += b_cnt[i];
            req_scale[i*SW +: SW] = b_scale[i];
            req[i] = (b_cnt[i] > 0);
        end
        guard = 0;
        while (total > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && rem[i] > 0) begin
                    rem[i]--;
                    total--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        if (total > 0) begin
            n_checks++;
            $display("FAIL batch_timeout: %0d grants outstanding, required 0", total);
            req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every grant, and times div_reset against the falls it sees
    initial begin : monitor
        exp_t e;
        logic prev_div, prev_drst, prev_busy, exp_load;
        logic [NREQ-1:0] prev_gnt;
        prev_div = 1'b0; prev_drst = 1'b0; prev_busy = 1'b0; exp_load = 1'b0; prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_load = 1'b0; prev_gnt = '0; prev_busy = 1'b0; prev_drst = 1'b0;
                prev_div = div_clk_out;
            end else begin
                if (!no_edge_mode && (exp_load || div_reset))
                    check("div_reset_after_fall", 64'(div_reset), 64'(exp_load));
                if (prev_gnt != '0) check("idle_after_ack", 64'(busy), 0);
                if (gnt != '0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_gnt: got gnt=%b, required no grant", gnt);
                    end else begin
                        e = exp_q.pop_front();
                        check("gnt_onehot", 64'(gnt), 64'(NREQ'(1) << e.idx));
                        check("scale", 64'(scale), 64'(e.scale));
                        check("clamped", 64'(clamped), 64'(e.clamped));
                        check("timeout", 64'(timeout), 64'(e.tmo));
                        check("load_path", 64'({prev_drst, prev_busy, div_reset}),
                              e.load ? 64'(3'b110) : 64'(3'b000));
                    end
                end
                exp_load = busy && !div_reset && (gnt == '0) && prev_div && !div_clk_out;
                prev_div = div_clk_out; prev_drst = div_reset; prev_busy = busy; prev_gnt = gnt;
            end
        end
    end

    initial begin : driver
        int seen;
        int waited;
        int wait_cycles;
        int mask;
        reset = 1'b1; req = '0; req_scale = '0;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_scale", 64'(scale), DEF);
            check("rst_div_reset", 64'(div_reset), 1);
            check("rst_busy", 64'(busy), 0);
            check("rst_gnt", 64'(gnt), 0);
        end
        #2 reset = 1'b1;
        @(negedge clk);
        check("div_reset_released", 64'(div_reset), 0);
        check("busy_released", 64'(busy), 0);

        set_batch(20, 30, 0, 40, 2, 1, 0, 1); run_batch();   // contention 0,1,3,0
        set_batch(0, 10, 0, 0, 0, 1, 0, 0);   run_batch();   // single change
        set_batch(0, 0, 0, 10, 0, 0, 0, 1);   run_batch();   // equal scale
        set_batch(0, 0, 1000, 0, 0, 0, 2, 0); run_batch();   // load then equal
        set_batch(0, 1, 0, 0, 1, 1, 0, 0);    run_batch();   // clamp: load then equal-clamped

        for (int n = 0; n < 20; n++) begin
            mask = int'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       b_scale[i] = SW'($urandom_range(0, 1));
                    1:       b_scale[i] = scale_m;
                    default: b_scale[i] = SW'($urandom_range(2, 60));
                endcase
                b_cnt[i] = mask[i] ? int'($urandom_range(1, 2)) : 0;
            end
            run_batch();
        end

        // Reset in the middle of an edge wait
        hold_mode = 1'b1; hold_val = 1'b1; no_edge_mode = 1'b1;
        repeat (3) @(negedge clk);
        req_scale[2*SW +: SW] = SW'(77); req[2] = 1'b1;
        waited = 0;
        while (!busy && waited < 20) begin @(negedge clk); waited++; end
        check("midwait_busy", 64'(busy), 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0; req = '0;
        @(negedge clk);
        check("midwait_scale", 64'(scale), DEF);
        check("midwait_busy_clear", 64'(busy), 0);
        check("midwait_gnt", 64'(gnt), 0);
        ptr_m = 0; scale_m = DEF;
        release_reset();
        repeat (20) @(negedge clk);
        hold_mode = 1'b0; no_edge_mode = 1'b0;
        repeat (3) @(negedge clk);
        set_batch(5, 6, 0, 0, 1, 1, 0, 0); run_batch();      // pointer back at 0

        hold_mode = 1'b1; hold_val = 1'b0; no_edge_mode = 1'b1;
        repeat (3) @(negedge clk);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        begin
            exp_t e;
            e.idx = 0; e.scale = SW'(50); e.clamped = 1'b0; e.load = 1'b1; e.tmo = 1'b1;
            exp_q.push_back(e);
            scale_m = SW'(50); ptr_m = 1;
        end
        req_scale[0 +: SW] = SW'(50); req[0] = 1'b1;
        waited = 0; wait_cycles = 0;
        while (!div_reset && waited < 200) begin
            @(negedge clk);
            waited++;
            if (busy && !div_reset) wait_cycles++;
        end
        check("timeout_wait_cycles", 64'(wait_cycles), TMO);
        waited = 0;
        while (gnt == '0 && waited < 20) begin @(negedge clk); waited++; end
        req = '0;
        check("timeout_gnt_seen", 64'(gnt[0]), 1);
        repeat (2) @(negedge clk);
`else
        req_scale[0 +: SW] = SW'(50); req[0] = 1'b1;
        seen = 0; wait_cycles = 0;
        repeat (1000) begin
            @(negedge clk);
            if (gnt != '0) seen++;
        end
        check("no_gnt_without_timeout", 64'(seen), 0);
        check("still_waiting", 64'(busy), 1);
        check("timeout_tied_low", 64'(timeout), 0);
        #1 reset = 1'b0; req = '0;
        ptr_m = 0; scale_m = DEF;
        release_reset();
        repeat (2) @(negedge clk);
`endif
        hold_mode = 1'b0; no_edge_mode = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Scale controller for the programmable clock divider. Accepts divide-ratio change requests from up to `NREQ` requesters, arbitrates them round-robin, and applies the winning `scale` to the divider only at a clean boundary: just after a falling edge of the divider's `clk_out`. At that point it pulses the divider's reset so the new ratio starts from a known phase. It sits between the configuration masters and the divider and is the only block that drives the divider's `scale` and `reset`.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 1..8.
- `SCALE_W`, 32: width of a scale value.
- `DEFAULT_SCALE`, 1000: scale driven out of reset.
- `MIN_SCALE`, 2: smallest legal scale; smaller requests are clamped up to this value.
- `TIMEOUT`, 65535: edge-wait limit in `clk` cycles; used only with `CLK_DIV_CTRL_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: system clock, the same clock that drives the divider.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, `NREQ`: per-requester change request, level; hold until `gnt`.
- `req_scale`, input, `NREQ*SCALE_W`: requested scale; requester i occupies bits `[i*SCALE_W +: SCALE_W]`.
- `gnt`, output, `NREQ`: one-hot, one-cycle completion pulse to the served requester.
- `clamped`, output, 1: one-cycle pulse with `gnt` when the applied value was clamped.
- `busy`, output, 1: high from the latch cycle through the ACK cycle.
- `div_clk_out`, input, 1: divider output, synchronous to `clk`.
- `scale`, output, `SCALE_W`: scale value driven to the divider.
- `div_reset`, output, 1: active-high reset to the divider.
- `timeout`, output, 1: one-cycle pulse when a load was forced; tied to 0 without the macro.

## Operation

The controller has four states: IDLE, WAIT_EDGE, LOAD and ACK.

- **IDLE**
  - When any `req` is high, latch the winner index, its `req_scale` clamped to `MIN_SCALE`, and the clamp flag.
  - If the clamped value equals the current `scale`, go to ACK. Otherwise go to WAIT_EDGE.
- **WAIT_EDGE**
  - A falling edge is detected when the registered `div_clk_out` is 1 and the current `div_clk_out` is 0.
  - On detection, go to LOAD.
- **LOAD**
  - `scale` takes the pending value.
  - `div_reset` is high for exactly this one cycle.
  - Go to ACK.
- **ACK**
  - `gnt[winner]` and `clamped` are valid for one cycle.
  - The round-robin pointer moves to winner+1 (mod `NREQ`).
  - Go to IDLE.

Arbitration rules:
- Round-robin search starts at the pointer. After reset the pointer is 0, so requester 0 has highest priority.
- Requests are sampled only in IDLE. A `req` dropped before it is latched is never served.
- A latched request completes even if its `req` drops afterwards.
- `req_scale` of the winner is sampled once, at latch. Later changes are ignored.
- The clamp compare is unsigned: values below `MIN_SCALE`, including 0, become `MIN_SCALE`.

Reset:
- While `reset` is low: `scale`=`DEFAULT_SCALE`, `div_reset`=1, `gnt`=0, `clamped`=0, `busy`=0, `timeout`=0, state=IDLE, pointer=0, edge register=0.
- `div_reset` falls on the first `clk` edge after `reset` releases.
- Reset asserted mid-operation aborts the transaction with no `gnt`, and `scale` returns to `DEFAULT_SCALE`.

## Timing

- Request sampled at edge N (IDLE). The state is WAIT_EDGE, and `busy`=1, from N+1.
- First falling edge of `div_clk_out` seen at edge M. LOAD occupies cycle M+1: `scale` updates and `div_reset`=1.
- ACK occupies cycle M+2 (`gnt` high). Back in IDLE at M+3, where a new request can be sampled.
- Equal-scale path: `gnt` is high in cycle N+1. No `div_reset` pulse, and `scale` is unchanged.
- Requests from several requesters are served one per transaction, back-to-back, in round-robin order. There is no idle gap beyond the ACK→IDLE cycle.
- `gnt` is never asserted in the same cycle as `div_reset`.

## Configuration

Macro: `CLK_DIV_CTRL_TIMEOUT_EN`.

- **Defined:**
  - A counter runs in WAIT_EDGE.
  - If no falling edge is seen within `TIMEOUT` cycles, the controller enters LOAD anyway (`TIMEOUT` cycles after WAIT_EDGE entry).
  - `timeout` pulses in the ACK cycle.
  - The counter clears on every WAIT_EDGE entry.
- **Not defined:**
  - WAIT_EDGE waits indefinitely.
  - `timeout` is constant 0 and the counter is not built.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles, then release → `scale`=1000 and `div_reset`=1 during reset; `div_reset`=0 one cycle after release; `busy`=0.
- **Single change:** req[1]=1 with scale 10 → `scale`=10 and a one-cycle `div_reset` in the cycle after the first `div_clk_out` fall; `gnt`=4'b0010 one cycle later; the divider then toggles every 10 cycles.
- **Contention:** req=4'b1011 held, each requesting a distinct scale (20, 30, _, 40) → grants in order 0, 1, 3, then 0 again if still requesting; each `gnt` is one-hot.
- **Equal and clamp:** request 1000 → `gnt` in cycle N+1 with no `div_reset`. Request 0 → `scale`=2 with `clamped`=1 alongside `gnt`.
- **Reset mid-wait:** `reset` low while in WAIT_EDGE → no `gnt` is ever issued for that request; `scale`=1000; `busy`=0.
- **Timeout (macro defined, `TIMEOUT`=16):** hold `div_clk_out` at 0 and request 50 → LOAD in the 16th WAIT_EDGE cycle, then `gnt` and `timeout` pulse together. Without the macro, no `gnt` after 1000 cycles.
